// File: rtl/bird_frame_painter.sv
// Per-frame bird sprite sequencer: erase, advance and redraw each slot,
// streaming one registered pixel per cycle to vga_adapter.
module bird_frame_painter #(
    parameter int NUM_BIRDS = 2,
    parameter int Y_FIRST   = 20,
    parameter int Y_SPACING = 16,
    parameter int X_MAX     = 159,
    parameter int STEP      = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [NUM_BIRDS-1:0] bird_en,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_n;
    logic [3:0] k, k_n;
    logic [1:0] slot, slot_n;

    logic [7:0] ax [4];
    logic [3:0] drawn;
    logic [3:0] en_ext;

    logic [7:0]        ax_cur;
    logic [8:0]        ax_sum;
    logic [7:0]        ax_next;
    logic [8:0]        ay;
    logic signed [3:0] dx, dy;
    logic signed [8:0] px, py;
    logic              in_bounds;

    always_comb begin
        en_ext = '0;
        en_ext[NUM_BIRDS-1:0] = bird_en;
    end

    always_comb begin
        dx = 4'sd0;
        dy = 4'sd0;
        unique case (k)
            4'd0:  begin dx =  4'sd0; dy =  4'sd0; end
            4'd1:  begin dx =  4'sd0; dy =  4'sd1; end
            4'd2:  begin dx = -4'sd1; dy =  4'sd0; end
            4'd3:  begin dx = -4'sd2; dy =  4'sd0; end
            4'd4:  begin dx = -4'sd3; dy =  4'sd0; end
            4'd5:  begin dx = -4'sd4; dy =  4'sd0; end
            4'd6:  begin dx = -4'sd5; dy =  4'sd0; end
            4'd7:  begin dx = -4'sd3; dy =  4'sd1; end
            4'd8:  begin dx = -4'sd3; dy = -4'sd1; end
            4'd9:  begin dx = -4'sd4; dy =  4'sd2; end
            4'd10: begin dx = -4'sd4; dy = -4'sd2; end
            4'd11: begin dx = -4'sd5; dy =  4'sd3; end
            4'd12: begin dx = -4'sd5; dy = -4'sd3; end
            default: begin dx = 4'sd0; dy = 4'sd0; end
        endcase
    end

    // Pixel position in 9-bit signed so sprites hanging off the left edge clip
    always_comb begin
        ax_cur    = ax[slot];
        ay        = 9'(Y_FIRST + int'(slot) * Y_SPACING);
        px        = $signed({1'b0, ax_cur}) + $signed({{5{dx[3]}}, dx});
        py        = $signed(ay) + $signed({{5{dy[3]}}, dy});
        in_bounds = !px[8] && (px <= 9'sd159) && !py[8] && (py <= 9'sd119);
    end

    always_comb begin
        ax_sum  = {1'b0, ax_cur} + 9'(STEP);
        ax_next = (ax_sum > 9'(X_MAX)) ? 8'(ax_sum - 9'(X_MAX) - 9'd1)
                                       : ax_sum[7:0];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= '0;
            slot  <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            slot  <= slot_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        slot_n  = slot;
        unique case (state)
            S_IDLE: begin
                // frame_done still high means the DONE cycle is visible downstream
                if (frame_tick && !frame_done) begin
                    state_n = S_ERASE;
                    k_n     = '0;
                    slot_n  = '0;
                end
            end
            S_ERASE: begin
                if (k == 4'd12) begin
                    state_n = S_MOVE;
                    k_n     = '0;
                end else begin
                    k_n = k + 4'd1;
                end
            end
            S_MOVE: begin
                state_n = S_DRAW;
                k_n     = '0;
            end
            S_DRAW: begin
                if (k == 4'd12) begin
                    state_n = S_NEXT;
                    k_n     = '0;
                end else begin
                    k_n = k + 4'd1;
                end
            end
            S_NEXT: begin
                if (slot == 2'(NUM_BIRDS - 1)) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_ERASE;
                    slot_n  = slot + 2'd1;
                    k_n     = '0;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) ax[i] <= '0;
            drawn <= '0;
        end else if (state == S_MOVE) begin
            drawn[slot] <= en_ext[slot];
            if (en_ext[slot]) ax[slot] <= ax_next;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            plot       <= 1'b0;
            busy       <= (state == S_ERASE) || (state == S_MOVE) ||
                          (state == S_DRAW)  || (state == S_NEXT);
            frame_done <= (state == S_DONE);
            if (state == S_ERASE) begin
                x      <= px[7:0];
                y      <= py[6:0];
                colour <= 3'b000;
                plot   <= drawn[slot] && in_bounds;
            end else if (state == S_DRAW) begin
                x      <= px[7:0];
                y      <= py[6:0];
                colour <= 3'b111;
                plot   <= drawn[slot] && in_bounds;
            end
        end
    end

endmodule

// File: tb/tb_bird_frame_painter.sv
// Bench for bird_frame_painter: per-cycle comparison of every pass
// against a pass-level model of the bird positions and sprite.
module tb_bird_frame_painter;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [1:0] bird_en;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int ax_m [2];
    bit drawn_m [2];

    int dxs [13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
    int dys [13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

    bird_frame_painter dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .frame_tick (frame_tick),
        .bird_en    (bird_en),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One full pass; extra_c>0 raises frame_tick again during cycle extra_c
    task automatic run_pass(input logic [1:0] en, input int extra_c);
        int  ax_old [2];
        int  ax_new [2];
        bit  d_old [2];
        bit  d_new [2];
        for (int i = 0; i < 2; i++) begin
            ax_old[i] = ax_m[i];
            d_old[i]  = drawn_m[i];
            ax_new[i] = en[i] ? (ax_m[i] + 1) % 160 : ax_m[i];
            d_new[i]  = en[i];
        end
        @(negedge CLOCK_50);
        bird_en    = en;
        frame_tick = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        frame_tick = 1'b0;
        for (int c = 1; c <= 59; c++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            cyc = c;
            chk("busy", busy, (c <= 56) ? 1 : 0);
            chk("frame_done", frame_done, (c == 57) ? 1 : 0);
            if (c <= 56) begin
                int s, r, kk, axv, px, py;
                bit dv, pix, inb;
                s   = (c - 1) / 28;
                r   = (c - 1) % 28;
                pix = (r < 13) || (r >= 14 && r <= 26);
                if (pix) begin
                    kk  = (r < 13) ? r : r - 14;
                    axv = (r < 13) ? ax_old[s] : ax_new[s];
                    dv  = (r < 13) ? d_old[s] : d_new[s];
                    px  = axv + dxs[kk];
                    py  = 20 + 16 * s + dys[kk];
                    inb = px >= 0 && px <= 159 && py >= 0 && py <= 119;
                    chk("x", x, px & 255);
                    chk("y", y, py & 127);
                    chk("colour", colour, (r < 13) ? 0 : 7);
                    chk("plot", plot, (dv && inb) ? 1 : 0);
                end else begin
                    chk("plot_gap", plot, 0);
                end
            end else begin
                chk("plot_idle", plot, 0);
            end
            frame_tick = (c == extra_c) ? 1'b1 : 1'b0;
        end
        frame_tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ax_m[i]    = ax_new[i];
            drawn_m[i] = d_new[i];
        end
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        bird_en    = 2'b00;
        ax_m       = '{0, 0};
        drawn_m    = '{0, 0};
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        reset = 1'b0;

        // first and second frame with slot 0 only
        run_pass(2'b01, 0);
        run_pass(2'b01, 0);

        // ticks while busy and in/after the DONE cycle
        run_pass(2'b01, 20);
        run_pass(2'b11, 56);
        run_pass(2'b11, 57);

        // disable then stay disabled
        run_pass(2'b00, 0);
        run_pass(2'b00, 0);
        run_pass(2'b01, 0);

        // walk slot 0 up to the right edge, then wrap
        while (ax_m[0] != 159) run_pass(2'b01, 0);
        run_pass(2'b01, 0);
        run_pass(2'b01, 0);

        // reset in cycle 20 of a pass
        @(negedge CLOCK_50);
        bird_en    = 2'b11;
        frame_tick = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        frame_tick = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        cyc = 21;
        chk("mid_rst_plot", plot, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_x", x, 0);
        @(negedge CLOCK_50);
        reset   = 1'b0;
        ax_m    = '{0, 0};
        drawn_m = '{0, 0};
        for (int c = 0; c < 60; c++) begin
            @(negedge CLOCK_50);
            cyc = 100 + c;
            chk("post_rst_plot", plot, 0);
            chk("post_rst_done", frame_done, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_pass(2'b11, 0);

        // randomized passes
        for (int n = 0; n < 40; n++) begin
            logic [1:0] en;
            int ex;
            en = 2'($urandom_range(0, 3));
            ex = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 57)) : 0;
            run_pass(en, ex);
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
